// File: rtl/rsa256_stream_wrapper_if.sv
// Byte-stream and RSA-core signal bundle for rsa256_stream_wrapper.
// The slave modport is the wrapper's view. The master modport is the view of
// the surrounding system: the upstream source, the downstream sink and the core.
interface rsa256_stream_wrapper_if;
   logic         i_rx_valid;
   logic [7:0]   i_rx_data;
   logic         o_rx_ready;
   logic         o_tx_valid;
   logic [7:0]   o_tx_data;
   logic         i_tx_ready;
   logic         o_core_start;
   logic [255:0] o_core_n;
   logic [255:0] o_core_d;
   logic [255:0] o_core_a;
   logic [255:0] i_core_a_pow_d;
   logic         i_core_finished;
   logic         i_key_reload;

   modport slave (
      input  i_rx_valid, i_rx_data, i_tx_ready, i_core_a_pow_d, i_core_finished, i_key_reload,
      output o_rx_ready, o_tx_valid, o_tx_data, o_core_start, o_core_n, o_core_d, o_core_a
   );

   modport master (
      output i_rx_valid, i_rx_data, i_tx_ready, i_core_a_pow_d, i_core_finished, i_key_reload,
      input  o_rx_ready, o_tx_valid, o_tx_data, o_core_start, o_core_n, o_core_d, o_core_a
   );
endinterface

// File: rtl/rsa256_stream_wrapper.sv
// Streams the modulus, private key and ciphertext in as bytes, most
// significant byte first. It then starts the RSA core and streams the low
// OUT_BYTES bytes of the result out, most significant byte first. The key is
// kept for later blocks unless a reload is requested.
module rsa256_stream_wrapper #(
   parameter int OUT_BYTES = 31
) (
   input logic                    i_clk,
   input logic                    i_rst_n,
   rsa256_stream_wrapper_if.slave bus
);

   localparam int TOP_LSB = OUT_BYTES * 8 - 8;

   typedef enum logic [2:0] {
      S_GET_N,
      S_GET_D,
      S_GET_A,
      S_START,
      S_WAIT,
      S_SEND
   } state_t;

   state_t       r_state;
   logic [5:0]   r_cnt;
   logic [255:0] r_n;
   logic [255:0] r_d;
   logic [255:0] r_a;
   logic [255:0] r_result;
   logic         r_reload_pending;
   logic         r_rx_ready;
   logic         r_tx_valid;
   logic [7:0]   r_tx_data;
   logic         r_core_start;

   logic         w_rx_accept;
   logic         w_tx_accept;
   logic         w_last_in;
   logic         w_last_out;
   logic [8:0]   w_next_shift;
   logic [7:0]   w_next_byte;
   logic [7:0]   w_first_byte;

   assign w_rx_accept  = bus.i_rx_valid && r_rx_ready;
   assign w_tx_accept  = r_tx_valid && bus.i_tx_ready;
   assign w_last_in    = (r_cnt == 6'd31);
   assign w_last_out   = (r_cnt == 6'(OUT_BYTES - 1));
   // The next byte to send is byte r_cnt+1, counted from the top emitted byte.
   // On the last byte this amount wraps, but that value is never loaded.
   assign w_next_shift = 9'((OUT_BYTES - 2 - int'(r_cnt)) * 8);
   assign w_next_byte  = 8'(r_result >> w_next_shift);
   assign w_first_byte = 8'(bus.i_core_a_pow_d >> TOP_LSB);

   assign bus.o_rx_ready   = r_rx_ready;
   assign bus.o_tx_valid   = r_tx_valid;
   assign bus.o_tx_data    = r_tx_data;
   assign bus.o_core_start = r_core_start;
   assign bus.o_core_n     = r_n;
   assign bus.o_core_d     = r_d;
   assign bus.o_core_a     = r_a;

   // Main control FSM: operand assembly, core handoff and result streaming,
   // with every handshake output registered.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state          <= S_GET_N;
         r_cnt            <= 6'd0;
         r_n              <= '0;
         r_d              <= '0;
         r_a              <= '0;
         r_result         <= '0;
         r_reload_pending <= 1'b0;
         r_rx_ready       <= 1'b0;
         r_tx_valid       <= 1'b0;
         r_tx_data        <= 8'd0;
         r_core_start     <= 1'b0;
      end else begin
         case (r_state)
            S_GET_N: begin
               r_rx_ready <= 1'b1;
               if (w_rx_accept) begin
                  r_n <= {r_n[247:0], bus.i_rx_data};
                  if (w_last_in) begin
                     r_cnt   <= 6'd0;
                     r_state <= S_GET_D;
                  end else begin
                     r_cnt <= r_cnt + 6'd1;
                  end
               end
            end

            S_GET_D: begin
               r_rx_ready <= 1'b1;
               if (w_rx_accept) begin
                  r_d <= {r_d[247:0], bus.i_rx_data};
                  if (w_last_in) begin
                     r_cnt   <= 6'd0;
                     r_state <= S_GET_A;
                  end else begin
                     r_cnt <= r_cnt + 6'd1;
                  end
               end
            end

            S_GET_A: begin
               r_rx_ready <= 1'b1;
               if (bus.i_key_reload && (r_cnt == 6'd0)) begin
                  // A reload request wins over the ciphertext. A byte taken on
                  // the same edge already belongs to the new modulus.
                  r_state <= S_GET_N;
                  if (w_rx_accept) begin
                     r_n   <= {r_n[247:0], bus.i_rx_data};
                     r_cnt <= 6'd1;
                  end
               end else if (w_rx_accept) begin
                  r_a <= {r_a[247:0], bus.i_rx_data};
                  if (w_last_in) begin
                     r_cnt            <= 6'd0;
                     r_rx_ready       <= 1'b0;
                     r_core_start     <= 1'b1;
                     r_reload_pending <= 1'b0;
                     r_state          <= S_START;
                  end else begin
                     r_cnt <= r_cnt + 6'd1;
                  end
               end
            end

            S_START: begin
               r_core_start     <= 1'b0;
               r_reload_pending <= r_reload_pending | bus.i_key_reload;
               r_state          <= S_WAIT;
            end

            S_WAIT: begin
               r_reload_pending <= r_reload_pending | bus.i_key_reload;
               if (bus.i_core_finished) begin
                  r_result   <= bus.i_core_a_pow_d;
                  r_tx_data  <= w_first_byte;
                  r_tx_valid <= 1'b1;
                  r_cnt      <= 6'd0;
                  r_state    <= S_SEND;
               end
            end

            S_SEND: begin
               r_reload_pending <= r_reload_pending | bus.i_key_reload;
               if (w_tx_accept) begin
                  if (w_last_out) begin
                     r_tx_valid       <= 1'b0;
                     r_tx_data        <= 8'd0;
                     r_cnt            <= 6'd0;
                     r_rx_ready       <= 1'b1;
                     r_reload_pending <= 1'b0;
                     r_state          <= (r_reload_pending || bus.i_key_reload) ? S_GET_N : S_GET_A;
                  end else begin
                     r_tx_data <= w_next_byte;
                     r_cnt     <= r_cnt + 6'd1;
                  end
               end
            end

            default: begin
               r_state <= S_GET_N;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rsa256_stream_wrapper.sv
// Self-checking bench for rsa256_stream_wrapper. A small core model answers
// start pulses with a^d mod n. The expected plaintext bytes are derived from
// the operands the bench sent and compared on every downstream handshake.
module tb_rsa256_stream_wrapper;

   localparam int OUT_BYTES = 31;

   localparam logic [255:0] N1 = 256'd3233;
   localparam logic [255:0] D1 = 256'd2753;
   localparam logic [255:0] A1 = 256'd2790;
   localparam logic [255:0] A_REUSE = 256'd3232;
   localparam logic [255:0] N2 = 256'd143;
   localparam logic [255:0] D2 = 256'd103;
   localparam logic [255:0] A2 = 256'd2;

   logic clk;
   logic rst_n;
   logic coreFinishedModel;
   logic spuriousFinish;

   int checkCount = 0;
   int passCount = 0;
   int startPulses = 0;
   int expectedStarts = 0;
   int txIndex = 0;
   logic [7:0] expQ[$];
   logic [255:0] modelN = '0;
   logic [255:0] modelD = '0;
   logic [255:0] modelA = '0;

   rsa256_stream_wrapper_if bus();

   assign bus.i_core_finished = coreFinishedModel | spuriousFinish;

   rsa256_stream_wrapper #(.OUT_BYTES(OUT_BYTES)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net in case a wait is left unbounded by mistake.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [255:0] modExp(input logic [255:0] base, input logic [255:0] expo,
                                           input logic [255:0] modulus);
      logic [63:0] m;
      logic [63:0] b;
      logic [63:0] r;
      m = modulus[63:0];
      b = 64'(base % modulus);
      r = 64'd1 % m;
      for (int i = 0; i < 256; i++) begin
         if (expo[i]) r = (r * b) % m;
         b = (b * b) % m;
      end
      return {192'd0, r};
   endfunction

   task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
      checkCount++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end else begin
         passCount++;
      end
   endtask

   // Offers one byte upstream from a falling edge and returns at the falling
   // edge after the byte was taken. With gap set, valid is held low for one
   // cycle first.
   task automatic applyStimulus(input logic [7:0] b, input bit gap);
      int waitCycles;
      waitCycles = 0;
      if (gap) begin
         bus.i_rx_valid = 1'b0;
         @(negedge clk);
      end
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = b;
      while (!bus.o_rx_ready && waitCycles < 200) begin
         @(negedge clk);
         waitCycles++;
      end
      if (waitCycles >= 200) checkOutput("rx_accept", {255'd0, bus.o_rx_ready}, 256'd1);
      @(negedge clk);
      bus.i_rx_valid = 1'b0;
   endtask

   task automatic sendOperand(input logic [255:0] v, input bit gap);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(v[255 - 8 * i -: 8], gap);
      end
   endtask

   task automatic expectBlock(input logic [255:0] res);
      for (int k = 0; k < OUT_BYTES; k++) begin
         expQ.push_back(8'(res >> ((OUT_BYTES - 1 - k) * 8)));
      end
   endtask

   task automatic sendA(input logic [255:0] a, input bit gap);
      modelA = a;
      expectedStarts++;
      expectBlock(modExp(a, modelD, modelN));
      sendOperand(a, gap);
   endtask

   task automatic sendKeyAndA(input logic [255:0] n, input logic [255:0] d, input logic [255:0] a, input bit gap);
      sendOperand(n, gap);
      sendOperand(d, gap);
      modelN = n;
      modelD = d;
      sendA(a, gap);
   endtask

   task automatic waitTxDone();
      int waitCycles;
      waitCycles = 0;
      while ((expQ.size() != 0 || bus.o_tx_valid) && waitCycles < 3000) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("tx_drained", 256'(expQ.size()), 256'd0);
      checkOutput("core_start_count", 256'(startPulses), 256'(expectedStarts));
   endtask

   // Core model: sees a start pulse, takes the operands on the core bus and
   // raises finished for one cycle, 10 cycles later.
   initial begin
      logic [255:0] cn, cd, ca;
      coreFinishedModel = 1'b0;
      bus.i_core_a_pow_d = '0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.o_core_start) begin
            cn = bus.o_core_n;
            cd = bus.o_core_d;
            ca = bus.o_core_a;
            repeat (10) @(negedge clk);
            bus.i_core_a_pow_d = modExp(ca, cd, cn);
            coreFinishedModel  = 1'b1;
            checkOutput("core_n_hold", bus.o_core_n, cn);
            checkOutput("core_d_hold", bus.o_core_d, cd);
            checkOutput("core_a_hold", bus.o_core_a, ca);
            @(negedge clk);
            coreFinishedModel = 1'b0;
         end
      end
   end

   // Compare process: runs just after every falling edge. It checks the
   // operands on each start pulse, that data holds during a stall, and each
   // accepted byte against the expected queue.
   initial begin
      logic prevStall;
      logic [7:0] prevData;
      logic [7:0] expByte;
      prevStall = 1'b0;
      prevData  = 8'd0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            txIndex   = 0;
            prevStall = 1'b0;
         end else begin
            if (bus.o_core_start) begin
               startPulses++;
               checkOutput("core_n_at_start", bus.o_core_n, modelN);
               checkOutput("core_d_at_start", bus.o_core_d, modelD);
               checkOutput("core_a_at_start", bus.o_core_a, modelA);
            end
            if (prevStall) begin
               checkOutput("tx_valid_hold", {255'd0, bus.o_tx_valid}, 256'd1);
               checkOutput("tx_data_hold", {248'd0, bus.o_tx_data}, {248'd0, prevData});
            end
            if (bus.o_tx_valid && bus.i_tx_ready) begin
               checkOutput("tx_expected", {255'd0, expQ.size() > 0}, 256'd1);
               if (expQ.size() > 0) begin
                  expByte = expQ.pop_front();
                  checkOutput("tx_byte", {248'd0, bus.o_tx_data}, {248'd0, expByte});
               end
               txIndex = (txIndex + 1 == OUT_BYTES) ? 0 : txIndex + 1;
            end
            prevStall = bus.o_tx_valid && !bus.i_tx_ready;
            prevData  = bus.o_tx_data;
         end
      end
   end

   // Directed scenario sequence.
   initial begin
      int waitCycles;
      rst_n            = 1'b0;
      spuriousFinish   = 1'b0;
      bus.i_rx_valid   = 1'b0;
      bus.i_rx_data    = 8'd0;
      bus.i_tx_ready   = 1'b1;
      bus.i_key_reload = 1'b0;

      // Pin the reference arithmetic to hand-computed values.
      checkOutput("model_basic", modExp(A1, D1, N1), 256'd65);
      checkOutput("model_reuse", modExp(A_REUSE, D1, N1), 256'd3232);

      // Reset state.
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_rx_ready", {255'd0, bus.o_rx_ready}, 256'd0);
      checkOutput("rst_tx_valid", {255'd0, bus.o_tx_valid}, 256'd0);
      checkOutput("rst_tx_data", {248'd0, bus.o_tx_data}, 256'd0);
      checkOutput("rst_core_start", {255'd0, bus.o_core_start}, 256'd0);
      checkOutput("rst_core_n", bus.o_core_n, 256'd0);
      checkOutput("rst_core_a", bus.o_core_a, 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic block.
      $display("[TB] basic block");
      sendOperand(N1, 1'b0);
      sendOperand(D1, 1'b0);
      modelN = N1;
      modelD = D1;
      modelA = A1;
      expectedStarts++;
      expectBlock(modExp(A1, D1, N1));
      checkOutput("model_first_byte", {248'd0, expQ[0]}, 256'h00);
      checkOutput("model_last_byte", {248'd0, expQ[OUT_BYTES - 1]}, 256'h41);
      sendOperand(A1, 1'b0);
      waitTxDone();

      // A finished pulse while a ciphertext is expected changes nothing.
      $display("[TB] spurious finish");
      spuriousFinish = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checkOutput("spurious_tx_valid", {255'd0, bus.o_tx_valid}, 256'd0);
         checkOutput("spurious_core_start", {255'd0, bus.o_core_start}, 256'd0);
         checkOutput("spurious_rx_ready", {255'd0, bus.o_rx_ready}, 256'd1);
      end
      spuriousFinish = 1'b0;
      @(negedge clk);

      // Key reuse: only a new ciphertext is sent.
      $display("[TB] key reuse");
      sendA(A_REUSE, 1'b0);
      waitTxDone();

      // Backpressure: valid toggles during the load and sends stall at byte 3.
      $display("[TB] backpressure");
      sendA(A1, 1'b1);
      waitCycles = 0;
      while (!(bus.o_tx_valid && txIndex == 3) && waitCycles < 500) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("stall_reached", {255'd0, bus.o_tx_valid}, 256'd1);
      bus.i_tx_ready = 1'b0;
      repeat (5) @(negedge clk);
      bus.i_tx_ready = 1'b1;
      waitTxDone();

      // Reset in the middle of loading d, then a full reload.
      $display("[TB] reset mid-load");
      bus.i_key_reload = 1'b1;
      @(negedge clk);
      bus.i_key_reload = 1'b0;
      sendOperand(N1, 1'b0);
      for (int i = 0; i < 17; i++) applyStimulus(D1[255 - 8 * i -: 8], 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_core_n", bus.o_core_n, 256'd0);
      checkOutput("midrst_core_d", bus.o_core_d, 256'd0);
      checkOutput("midrst_rx_ready", {255'd0, bus.o_rx_ready}, 256'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      sendKeyAndA(N1, D1, A1, 1'b0);
      waitTxDone();

      // Reload requested while the core is busy.
      $display("[TB] reload during wait");
      sendA(A1, 1'b0);
      waitCycles = 0;
      while (!bus.o_core_start && waitCycles < 50) begin
         @(negedge clk);
         waitCycles++;
      end
      repeat (3) @(negedge clk);
      bus.i_key_reload = 1'b1;
      @(negedge clk);
      bus.i_key_reload = 1'b0;
      waitTxDone();
      @(negedge clk);
      #1;
      checkOutput("reload_rx_ready", {255'd0, bus.o_rx_ready}, 256'd1);
      sendKeyAndA(N2, D2, A2, 1'b0);
      waitTxDone();

      // Reload requested while idle between ciphertexts.
      $display("[TB] reload while idle");
      @(negedge clk);
      bus.i_key_reload = 1'b1;
      @(negedge clk);
      bus.i_key_reload = 1'b0;
      sendKeyAndA(N1, D1, A1, 1'b0);
      waitTxDone();

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
